// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bundle: instruction-SRAM request/response plus the IF->ID handshake and branch redirect.
// The master side is the fetch controller; the slave side is the SRAM and ID stage around it.
interface if_fetch_ctrl_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic                   br_taken_i;
  logic [PC_W-1:0]        br_target_i;
  logic                   id_allowin_i;
  logic                   if_to_id_valid_o;
  logic [PC_W+INST_W-1:0] pc_inst_obus;
  logic                   inst_sram_req_o;
  logic [PC_W-1:0]        inst_sram_addr_o;
  logic                   inst_sram_addr_ok_i;
  logic                   inst_sram_data_ok_i;
  logic [INST_W-1:0]      inst_sram_rdata_i;

  modport master (
    input  br_taken_i, br_target_i, id_allowin_i,
    input  inst_sram_addr_ok_i, inst_sram_data_ok_i, inst_sram_rdata_i,
    output if_to_id_valid_o, pc_inst_obus, inst_sram_req_o, inst_sram_addr_o
  );

  modport slave (
    output br_taken_i, br_target_i, id_allowin_i,
    output inst_sram_addr_ok_i, inst_sram_data_ok_i, inst_sram_rdata_i,
    input  if_to_id_valid_o, pc_inst_obus, inst_sram_req_o, inst_sram_addr_o
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: one outstanding SRAM read, one-entry instruction buffer, redirect cancellation.
// Zero-wait SRAM gives first valid 3 cycles after reset; ID stall holds the buffer, no new request.
module if_fetch_ctrl #(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h1C00_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  if_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic              discard_q, discard_d;
  logic [PC_W-1:0]   buf_pc_q, buf_pc_d;
  logic [INST_W-1:0] buf_inst_q, buf_inst_d;

  logic [PC_W-1:0] br_target_aligned;
  logic            valid_out;

  assign br_target_aligned = bus.br_target_i & ~PC_W'(3);
  // A redirect in the same cycle masks the transfer so ID never latches a wrong-path instruction.
  assign valid_out = (state_q == HOLD) & ~bus.br_taken_i;

  assign bus.if_to_id_valid_o = valid_out;
  assign bus.pc_inst_obus     = {buf_pc_q, buf_inst_q};
  assign bus.inst_sram_req_o  = (state_q == REQ);
  assign bus.inst_sram_addr_o = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (bus.br_taken_i) begin
          fetch_pc_d = br_target_aligned;
        end
      end

      REQ: begin
        if (bus.inst_sram_addr_ok_i) begin
          // The old address was already accepted, so its data must be thrown away.
          state_d = WAIT;
          if (bus.br_taken_i) begin
            fetch_pc_d = br_target_aligned;
            discard_d  = 1'b1;
          end
        end else if (bus.br_taken_i) begin
          fetch_pc_d = br_target_aligned;
        end
      end

      WAIT: begin
        if (bus.inst_sram_data_ok_i) begin
          if (bus.br_taken_i) begin
            fetch_pc_d = br_target_aligned;
            discard_d  = 1'b0;
            state_d    = REQ;
          end else if (discard_q) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            buf_pc_d   = fetch_pc_q;
            buf_inst_d = bus.inst_sram_rdata_i;
            state_d    = HOLD;
          end
        end else if (bus.br_taken_i) begin
          fetch_pc_d = br_target_aligned;
          discard_d  = 1'b1;
        end
      end

      HOLD: begin
        if (bus.br_taken_i) begin
          fetch_pc_d = br_target_aligned;
          state_d    = REQ;
        end else if (bus.id_allowin_i) begin
          fetch_pc_d = fetch_pc_q + PC_W'(4);
          state_d    = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      buf_pc_q   <= '0;
      buf_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: SRAM and ID are driven cycle by cycle from the initial block.
module tb_if_fetch_ctrl;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  if_fetch_ctrl_if #(.PC_W(PC_W), .INST_W(INST_W)) sif ();

  if_fetch_ctrl #(
    .PC_W    (PC_W),
    .INST_W  (INST_W),
    .RESET_PC(32'h1C00_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait transaction starting in REQ; leaves the DUT in HOLD.
  task automatic fetch_one(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    chk({tag, "_req"}, 64'(sif.inst_sram_req_o), 64'd1);
    chk({tag, "_addr"}, 64'(sif.inst_sram_addr_o), 64'(exp_addr));
    sif.inst_sram_addr_ok_i = 1'b1;
    step();
    sif.inst_sram_addr_ok_i = 1'b0;
    chk({tag, "_req_wait"}, 64'(sif.inst_sram_req_o), 64'd0);
    sif.inst_sram_data_ok_i = 1'b1;
    sif.inst_sram_rdata_i   = data;
    step();
    sif.inst_sram_data_ok_i = 1'b0;
    sif.inst_sram_rdata_i   = '0;
    chk({tag, "_valid"}, 64'(sif.if_to_id_valid_o), 64'd1);
    chk({tag, "_bus"}, sif.pc_inst_obus, {exp_addr, data});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    sif.br_taken_i          = 1'b0;
    sif.br_target_i         = '0;
    sif.id_allowin_i        = 1'b0;
    sif.inst_sram_addr_ok_i = 1'b0;
    sif.inst_sram_data_ok_i = 1'b0;
    sif.inst_sram_rdata_i   = '0;

    step();
    step();
    chk("rst_req", 64'(sif.inst_sram_req_o), 64'd0);
    chk("rst_valid", 64'(sif.if_to_id_valid_o), 64'd0);
    chk("rst_bus", sif.pc_inst_obus, 64'd0);
    chk("rst_addr", 64'(sif.inst_sram_addr_o), 64'h1C00_0000);

    // First fetch: IDLE -> REQ -> WAIT -> HOLD, valid three edges after release.
    rst_n = 1'b1;
    step();
    fetch_one("f0", 32'h1C00_0000, 32'h0280_0000);
    sif.id_allowin_i = 1'b1;
    step();
    sif.id_allowin_i = 1'b0;
    chk("f0_next_addr", 64'(sif.inst_sram_addr_o), 64'h1C00_0004);

    // ID stall: buffer and valid held, no new request.
    fetch_one("f1", 32'h1C00_0004, 32'h1111_1111);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 64'(sif.if_to_id_valid_o), 64'd1);
      chk("stall_bus", sif.pc_inst_obus, {32'h1C00_0004, 32'h1111_1111});
      chk("stall_req", 64'(sif.inst_sram_req_o), 64'd0);
    end
    sif.id_allowin_i = 1'b1;
    step();
    sif.id_allowin_i = 1'b0;
    chk("stall_next_addr", 64'(sif.inst_sram_addr_o), 64'h1C00_0008);

    // Redirect while waiting for data: the late data is dropped.
    sif.inst_sram_addr_ok_i = 1'b1;
    step();
    sif.inst_sram_addr_ok_i = 1'b0;
    sif.br_taken_i  = 1'b1;
    sif.br_target_i = 32'h1C00_0103;
    step();
    sif.br_taken_i = 1'b0;
    chk("wbr_req", 64'(sif.inst_sram_req_o), 64'd0);
    step();
    chk("wbr_valid1", 64'(sif.if_to_id_valid_o), 64'd0);
    sif.inst_sram_data_ok_i = 1'b1;
    sif.inst_sram_rdata_i   = 32'hDEAD_BEEF;
    step();
    sif.inst_sram_data_ok_i = 1'b0;
    chk("wbr_valid2", 64'(sif.if_to_id_valid_o), 64'd0);
    chk("wbr_req2", 64'(sif.inst_sram_req_o), 64'd1);
    chk("wbr_addr", 64'(sif.inst_sram_addr_o), 64'h1C00_0100);

    // Redirect in HOLD with allowin: same-cycle valid masked.
    fetch_one("f2", 32'h1C00_0100, 32'h2222_2222);
    sif.br_taken_i   = 1'b1;
    sif.br_target_i  = 32'h1C00_0200;
    sif.id_allowin_i = 1'b1;
    #1;
    chk("hbr_valid", 64'(sif.if_to_id_valid_o), 64'd0);
    step();
    sif.br_taken_i   = 1'b0;
    sif.id_allowin_i = 1'b0;
    chk("hbr_valid_after", 64'(sif.if_to_id_valid_o), 64'd0);
    chk("hbr_req", 64'(sif.inst_sram_req_o), 64'd1);
    chk("hbr_addr", 64'(sif.inst_sram_addr_o), 64'h1C00_0200);

    // Redirect coincident with addr_ok: returned data is discarded.
    sif.inst_sram_addr_ok_i = 1'b1;
    sif.br_taken_i          = 1'b1;
    sif.br_target_i         = 32'h1C00_0300;
    step();
    sif.inst_sram_addr_ok_i = 1'b0;
    sif.br_taken_i          = 1'b0;
    chk("abr_req", 64'(sif.inst_sram_req_o), 64'd0);
    sif.inst_sram_data_ok_i = 1'b1;
    sif.inst_sram_rdata_i   = 32'h3333_3333;
    step();
    sif.inst_sram_data_ok_i = 1'b0;
    chk("abr_valid", 64'(sif.if_to_id_valid_o), 64'd0);
    chk("abr_req2", 64'(sif.inst_sram_req_o), 64'd1);
    chk("abr_addr", 64'(sif.inst_sram_addr_o), 64'h1C00_0300);

    // Back-to-back redirects in REQ: the last target wins.
    sif.br_taken_i  = 1'b1;
    sif.br_target_i = 32'h1C00_0400;
    step();
    chk("bb_addr1", 64'(sif.inst_sram_addr_o), 64'h1C00_0400);
    sif.br_target_i = 32'h1C00_0500;
    step();
    sif.br_taken_i = 1'b0;
    chk("bb_addr2", 64'(sif.inst_sram_addr_o), 64'h1C00_0500);

    // PC wrap: low target bits forced to zero, +4 wraps to zero.
    sif.br_taken_i  = 1'b1;
    sif.br_target_i = 32'hFFFF_FFFF;
    step();
    sif.br_taken_i = 1'b0;
    fetch_one("wrap", 32'hFFFF_FFFC, 32'h4444_4444);
    sif.id_allowin_i = 1'b1;
    step();
    sif.id_allowin_i = 1'b0;
    chk("wrap_addr", 64'(sif.inst_sram_addr_o), 64'h0000_0000);

    // Reset during WAIT; stale data_ok after release must be ignored.
    sif.inst_sram_addr_ok_i = 1'b1;
    step();
    sif.inst_sram_addr_ok_i = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mrst_req", 64'(sif.inst_sram_req_o), 64'd0);
    chk("mrst_addr", 64'(sif.inst_sram_addr_o), 64'h1C00_0000);
    chk("mrst_bus", sif.pc_inst_obus, 64'd0);
    rst_n = 1'b1;
    sif.inst_sram_data_ok_i = 1'b1;
    sif.inst_sram_rdata_i   = 32'h5555_5555;
    step();
    chk("mrst_valid", 64'(sif.if_to_id_valid_o), 64'd0);
    chk("mrst_req2", 64'(sif.inst_sram_req_o), 64'd1);
    chk("mrst_addr2", 64'(sif.inst_sram_addr_o), 64'h1C00_0000);
    step();
    sif.inst_sram_data_ok_i = 1'b0;
    sif.inst_sram_rdata_i   = '0;
    chk("req_dok_valid", 64'(sif.if_to_id_valid_o), 64'd0);
    fetch_one("f3", 32'h1C00_0000, 32'h6666_6666);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch-stage sequencer: generates fetch PCs and runs the instruction-SRAM request/response handshake.
- Buffers one returned instruction and drives the IF->ID valid/allowin handshake into the IF/ID pipeline register.
- Handles branch redirects from ID, cancelling in-flight or buffered fetches.
- Sits between the PC/instruction SRAM and the IF/ID register.

Parameters:
- RESET_PC, 32'h1C00_0000, first fetch address after reset.
- PC_W, 32, PC width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- br_taken_i  in  1  redirect request from ID, single-cycle.
- br_target_i  in  PC_W  redirect target; bits [1:0] are ignored and forced to 0.
- id_allowin_i  in  1  ID stage can accept an instruction this cycle.
- if_to_id_valid_o  out  1  pc_inst_obus holds a valid instruction for ID.
- pc_inst_obus  out  PC_W+INST_W  {pc, inst} to the IF/ID register.
- inst_sram_req_o  out  1  fetch request.
- inst_sram_addr_o  out  PC_W  fetch address.
- inst_sram_addr_ok_i  in  1  request accepted.
- inst_sram_data_ok_i  in  1  read data returned.
- inst_sram_rdata_i  in  INST_W  read data.

Behaviour:
- Reset (rst_n==0 at posedge):
  - state=IDLE, fetch_pc=RESET_PC, discard=0.
  - Buffered pc/inst = 0, inst_sram_req_o=0, if_to_id_valid_o=0, pc_inst_obus=0.
  - Reset mid-operation abandons any outstanding fetch.
  - data_ok in IDLE or REQ is ignored.
- States: IDLE, REQ, WAIT, HOLD. At most one SRAM transaction is outstanding.
- inst_sram_req_o = (state==REQ); inst_sram_addr_o = fetch_pc.
- IDLE: always goes to REQ on the next cycle.
- REQ:
  - On addr_ok: go to WAIT.
  - Without addr_ok: stay in REQ; the address may change only on a redirect (the slave samples it only with addr_ok).
- WAIT:
  - On data_ok with discard==0 and no br_taken: capture {fetch_pc, rdata} into the buffer, go to HOLD.
  - On data_ok with discard==1: drop the data, clear discard, go to REQ.
- HOLD:
  - if_to_id_valid_o = (state==HOLD) & ~br_taken_i, combinational mask. A same-cycle redirect therefore cancels the transfer.
  - On if_to_id_valid_o & id_allowin_i: fetch_pc <= fetch_pc+4 (mod 2^PC_W, wraps), go to REQ.
  - Otherwise hold the buffer and valid stable (ID stall).
- Redirect (br_taken_i=1) per state:
  - IDLE/REQ: fetch_pc <= target next cycle; stay in or go to REQ. If addr_ok is in the same cycle, the handshake completes with the old address, discard <= 1, go to WAIT.
  - WAIT without data_ok: fetch_pc <= target, discard <= 1, stay in WAIT.
  - WAIT with data_ok: data dropped, fetch_pc <= target, discard <= 0, go to REQ.
  - HOLD: buffer invalidated, fetch_pc <= target, go to REQ. Applies even when id_allowin_i=1.
- Consecutive redirects: the last target wins. discard stays set until exactly one data_ok is consumed.
- Latency with zero-wait SRAM (addr_ok in the same cycle as req, data_ok one cycle later):
  - First if_to_id_valid_o rises 3 cycles after reset release.
  - Throughput is 1 instruction per 3 cycles with ID never stalling.
- pc_inst_obus always reflects the buffer. It is meaningful only when if_to_id_valid_o=1.

Test Plan:
- Reset release; SRAM answers addr_ok immediately and data_ok next cycle with 0x02800000 -> first req addr 0x1C000000; pc_inst_obus={0x1C000000,0x02800000} with valid high; next req addr 0x1C000004.
- ID holds id_allowin_i=0 for 5 cycles in HOLD -> valid and bus stable for 5 cycles; no new req; advances to 0x1C000008 after allowin=1.
- br_taken_i with target 0x1C000103 while in WAIT; data_ok 2 cycles later -> returned data never presented; next req addr 0x1C000100.
- br_taken_i=1 with id_allowin_i=1 in HOLD -> valid low that cycle; next req addr = target; old instruction never accepted by ID.
- br_taken_i coincident with addr_ok in REQ -> the following data_ok is dropped; the subsequent req carries the target.
- rst_n low while in WAIT, stale data_ok arrives after release -> ignored; first req again 0x1C000000.
- fetch_pc=0xFFFFFFFC accepted by ID -> next req addr 0x00000000.
